win_scan_seq: RTL

//  Sequential, parametrised win detector for a ROWS x COLS drop-token board.
//  On start, snapshots one player's occupancy vector and scans one anchor cell per cycle.

---
 rtl/win_scan_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/win_scan_seq.sv
// win_scan_seq: sequential ROWS x COLS line-of-WIN_LEN detector, one anchor cell per cycle
//
// Ports:
//    clk_i        system clock, all logic on posedge
//    reset_i      synchronous active-high reset
//    start_i      request a scan, accepted only when not busy
//    player_i     0 = scan red, 1 = scan blue (sampled with start)
//    red_i        red occupancy, bit index = row*COLS + col
//    blue_i       blue occupancy, same indexing
//    busy_o       scan in progress
//    done_o       one-cycle pulse, results valid from this cycle
//    win_o        selected player has a line
//    win_dir_o    0 horiz, 1 vert, 2 diag up-right, 3 diag up-left
//    win_row_o    row of the lowest-index cell of the winning line
//    win_col_o    col of the lowest-index cell of the winning line
//    draw_o       board full and no win
//    conflict_o   red and blue overlap at snapshot
module win_scan_seq #(
   parameter int ROWS = 6,
   parameter int COLS = 7,
   parameter int WIN_LEN = 4,
   localparam int N = ROWS * COLS,
   localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
   localparam int CW = COLS > 1 ? $clog2(COLS) : 1,
   localparam int AW = N > 1 ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic          player_i,
   input  logic [N-1:0]  red_i,
   input  logic [N-1:0]  blue_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          win_o,
   output logic [1:0]    win_dir_o,
   output logic [RW-1:0] win_row_o,
   output logic [CW-1:0] win_col_o,
   output logic          draw_o,
   output logic          conflict_o
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t        state_q;
   logic [N-1:0]  sel_q;
   logic          full_q;
   logic [AW-1:0] anchor_q;
   logic [RW-1:0] r_q;
   logic [CW-1:0] c_q;
   logic          busy_q, done_q, win_q, draw_q, conflict_q;
   logic [1:0]    dir_q;
   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;
   logic [3:0]    valid_d, hit_d;
   logic [1:0]    dir_d;
   logic [AW-1:0] idx;
   int            rr, cc;
   // Invalid directions read cell 0 instead of an off-board index; their hit is forced low anyway.
   always_comb begin
      valid_d[0] = int'(c_q) + WIN_LEN - 1 < COLS;
      valid_d[1] = int'(r_q) + WIN_LEN - 1 < ROWS;
      valid_d[2] = valid_d[0] && valid_d[1];
      valid_d[3] = int'(c_q) >= WIN_LEN - 1 && valid_d[1];
      hit_d = valid_d;
      rr = 0;
      cc = 0;
      idx = '0;
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < WIN_LEN; k++) begin
            rr = int'(r_q) + (d == 0 ? 0 : k);
            cc = int'(c_q) + (d == 1 ? 0 : d == 3 ? -k : k);
            idx = valid_d[d] ? AW'(rr * COLS + cc) : '0;
            hit_d[d] = hit_d[d] & sel_q[idx];
         end
      end
      dir_d = hit_d[0] ? 2'd0 : hit_d[1] ? 2'd1 : hit_d[2] ? 2'd2 : 2'd3;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         full_q     <= 1'b0;
         anchor_q   <= '0;
         r_q        <= '0;
         c_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         win_q      <= 1'b0;
         draw_q     <= 1'b0;
         conflict_q <= 1'b0;
         dir_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
      end else if (state_q == SCAN) begin
         if (|hit_d) begin
            win_q   <= 1'b1;
            dir_q   <= dir_d;
            row_q   <= r_q;
            col_q   <= c_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
         end else if (anchor_q == AW'(N - 1)) begin
            draw_q  <= full_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
         end else begin
            anchor_q <= anchor_q + 1'b1;
            c_q      <= c_q == CW'(COLS - 1) ? '0 : c_q + 1'b1;
            r_q      <= c_q == CW'(COLS - 1) ? r_q + 1'b1 : r_q;
         end
      end else begin
         done_q <= 1'b0;
         state_q <= start_i ? SCAN : IDLE;
         if (start_i) begin
            sel_q      <= player_i ? blue_i : red_i;
            full_q     <= &(red_i | blue_i);
            conflict_q <= |(red_i & blue_i);
            win_q      <= 1'b0;
            draw_q     <= 1'b0;
            dir_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            anchor_q   <= '0;
            r_q        <= '0;
            c_q        <= '0;
            busy_q     <= 1'b1;
         end
      end
   end
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign win_o      = win_q;
   assign win_dir_o  = dir_q;
   assign win_row_o  = row_q;
   assign win_col_o  = col_q;
   assign draw_o     = draw_q;
   assign conflict_o = conflict_q;
endmodule
